// File: rtl/preg_ready_table.sv
`default_nettype none
// ============================================================================
// Module      : preg_ready_table
// Description : Physical-register ready table for the rename stage. Binary
//               tags are decoded to one-hot masks. Dispatch clears a preg's
//               ready bit, a CDB broadcast sets it, and flush forces every bit
//               ready. Read ports return ready bits with same-cycle CDB bypass.
// Config      : PREG_ZERO_EN - when defined, preg 0 is hardwired ready.
// Revision    : 1.0 - initial release
// ============================================================================
module preg_ready_table #(
    parameter  int NUM_PREGS = 64,
    parameter  int NUM_READS = 2,
    localparam int TAG_W     = (NUM_PREGS > 1) ? $clog2(NUM_PREGS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         alloc_valid,
    input  logic [TAG_W-1:0]             alloc_tag,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [NUM_READS*TAG_W-1:0]   rd_tag,
    output logic [NUM_READS-1:0]         rd_ready,
    output logic [NUM_PREGS-1:0]         ready_vec,
    output logic [TAG_W:0]               busy_count,
    output logic                         tag_err
);

    // Tag count widened by one bit so the range check never folds to a constant
    localparam logic [TAG_W:0] C_NUM_PREGS = (TAG_W+1)'(NUM_PREGS);

    logic [NUM_PREGS-1:0] ready_q, ready_d;
    logic [TAG_W:0]       busy_q, busy_d;
    logic                 err_q, err_d;

    logic [NUM_PREGS-1:0] alloc_mask;
    logic [NUM_PREGS-1:0] cdb_mask;
    logic                 alloc_bad;
    logic                 cdb_bad;

    // Decode valid tags into one-hot masks; out-of-range tags decode to zero
    always_comb begin
        alloc_mask = '0;
        cdb_mask   = '0;
        for (int j = 0; j < NUM_PREGS; j++) begin
            alloc_mask[j] = alloc_valid && (alloc_tag == TAG_W'(j));
            cdb_mask[j]   = cdb_valid   && (cdb_tag   == TAG_W'(j));
        end
`ifdef PREG_ZERO_EN
        // preg 0 is the $zero mapping: requests to it are silently dropped
        alloc_mask[0] = 1'b0;
        cdb_mask[0]   = 1'b0;
`endif
        alloc_bad = alloc_valid && ({1'b0, alloc_tag} >= C_NUM_PREGS);
        cdb_bad   = cdb_valid   && ({1'b0, cdb_tag}   >= C_NUM_PREGS);
    end

    // Next ready vector (flush beats everything, clear beats set) and its busy count
    always_comb begin
        if (flush) begin
            ready_d = '1;
        end else begin
            ready_d = (ready_q | cdb_mask) & ~alloc_mask;
        end
`ifdef PREG_ZERO_EN
        ready_d[0] = 1'b1;
`endif
        busy_d = '0;
        for (int j = 0; j < NUM_PREGS; j++) begin
            busy_d = busy_d + {{TAG_W{1'b0}}, ~ready_d[j]};
        end
        err_d = alloc_bad | cdb_bad;
    end

    // State register: reset returns the table to all-ready
    always_ff @(posedge clock) begin
        if (reset) begin
            ready_q <= '1;
            busy_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign ready_vec  = ready_q;
    assign busy_count = busy_q;
    assign tag_err    = err_q;

    // Read ports: table lookup plus bypass of a CDB broadcast in the same cycle
    for (genvar i = 0; i < NUM_READS; i++) begin : g_rd
        logic [TAG_W-1:0] rd_t;
        logic             hit;
        logic             in_range;

        assign rd_t = rd_tag[i*TAG_W +: TAG_W];

        // Lookup is a mux over the table so out-of-range tags naturally read 0
        always_comb begin
            in_range = ({1'b0, rd_t} < C_NUM_PREGS);
            hit      = 1'b0;
            for (int j = 0; j < NUM_PREGS; j++) begin
                hit = hit | (ready_q[j] & (rd_t == TAG_W'(j)));
            end
            if (cdb_valid && in_range && (cdb_tag == rd_t)) begin
                hit = 1'b1;
            end
        end

        assign rd_ready[i] = hit;
    end

endmodule
`default_nettype wire

// File: tb/tb_preg_ready_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_preg_ready_table
// Description : Self-checking bench for preg_ready_table. Drives a 64-entry
//               and a 48-entry table with identical stimulus and compares both
//               against a bit-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_preg_ready_table;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        alloc_valid;
    logic [5:0]  alloc_tag;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [11:0] rd_tag;

    logic [1:0]  rd_ready64,  rd_ready48;
    logic [63:0] ready_vec64;
    logic [47:0] ready_vec48;
    logic [6:0]  busy64;
    logic [6:0]  busy48;
    logic        err64, err48;

    int total = 0;
    int fails = 0;

    bit [63:0] r64;
    bit [63:0] r48;
    bit        e64;
    bit        e48;

    always #5 clock = ~clock;

    preg_ready_table #(.NUM_PREGS(64), .NUM_READS(2)) u_dut64 (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .alloc_valid(alloc_valid),
        .alloc_tag  (alloc_tag),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .rd_tag     (rd_tag),
        .rd_ready   (rd_ready64),
        .ready_vec  (ready_vec64),
        .busy_count (busy64),
        .tag_err    (err64)
    );

    preg_ready_table #(.NUM_PREGS(48), .NUM_READS(2)) u_dut48 (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .alloc_valid(alloc_valid),
        .alloc_tag  (alloc_tag),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .rd_tag     (rd_tag),
        .rd_ready   (rd_ready48),
        .ready_vec  (ready_vec48),
        .busy_count (busy48),
        .tag_err    (err48)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit zero_fixed(input int t);
`ifdef PREG_ZERO_EN
        return (t == 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit [63:0] all_ready(input int n);
        bit [63:0] v = '0;
        for (int k = 0; k < n; k++) v[k] = 1'b1;
        return v;
    endfunction

    // Reference next state from the current inputs
    function automatic bit [63:0] model_next(input bit [63:0] cur, input int n);
        bit [63:0] nx = cur;
        int at = int'(alloc_tag);
        int ct = int'(cdb_tag);
        if (reset || flush) return all_ready(n);
        if (cdb_valid && ct < n && !zero_fixed(ct)) nx[ct] = 1'b1;
        if (alloc_valid && at < n && !zero_fixed(at)) nx[at] = 1'b0;
        return nx;
    endfunction

    function automatic bit model_err(input int n);
        if (reset) return 1'b0;
        return (alloc_valid && int'(alloc_tag) >= n) || (cdb_valid && int'(cdb_tag) >= n);
    endfunction

    function automatic int busy_of(input bit [63:0] r, input int n);
        int c = 0;
        for (int k = 0; k < n; k++) if (!r[k]) c++;
        return c;
    endfunction

    function automatic bit rd_exp(input bit [63:0] r, input int n, input int t);
        if (t >= n) return 1'b0;
        return r[t] || (cdb_valid && int'(cdb_tag) == t);
    endfunction

    // One cycle: check read ports mid-cycle, clock, then check registered state
    task automatic tick();
        bit [63:0] n64, n48;
        bit        ne64, ne48;
        #2;
        for (int p = 0; p < 2; p++) begin
            int t = int'(rd_tag[p*6 +: 6]);
            chk($sformatf("rd64[%0d] tag%0d", p, t), {63'b0, rd_ready64[p]}, {63'b0, rd_exp(r64, 64, t)});
            chk($sformatf("rd48[%0d] tag%0d", p, t), {63'b0, rd_ready48[p]}, {63'b0, rd_exp(r48, 48, t)});
        end
        n64  = model_next(r64, 64);
        n48  = model_next(r48, 48);
        ne64 = model_err(64);
        ne48 = model_err(48);
        @(posedge clock);
        #1;
        r64 = n64; r48 = n48; e64 = ne64; e48 = ne48;
        chk("vec64",  ready_vec64,            r64);
        chk("busy64", {57'b0, busy64},        64'(busy_of(r64, 64)));
        chk("err64",  {63'b0, err64},         {63'b0, e64});
        chk("vec48",  {16'b0, ready_vec48},   r48);
        chk("busy48", {57'b0, busy48},        64'(busy_of(r48, 48)));
        chk("err48",  {63'b0, err48},         {63'b0, e48});
    endtask

    task automatic idle();
        flush = 1'b0; alloc_valid = 1'b0; cdb_valid = 1'b0; reset = 1'b0;
    endtask

    initial begin
        r64 = all_ready(64);
        r48 = all_ready(48);
        reset = 1'b1; flush = 1'b0;
        alloc_valid = 1'b0; alloc_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0;
        rd_tag = {6'd63, 6'd5};
        repeat (2) @(posedge clock);
        #1;

        // Reset state, then idle with reads of tags 5 and 63
        tick();
        idle();
        tick();
        chk("idle rd64 tags 5/63", {62'b0, rd_ready64}, 64'd3);

        // Alloc 5, then CDB 5 with bypass on the read port
        rd_tag = {6'd5, 6'd5};
        alloc_valid = 1'b1; alloc_tag = 6'd5;
        tick();
        idle();
        tick();
        cdb_valid = 1'b1; cdb_tag = 6'd5;
        tick();
        idle();
        tick();

        // Alloc and CDB to the same tag: clear wins; re-alloc keeps it busy
        alloc_valid = 1'b1; alloc_tag = 6'd9; cdb_valid = 1'b1; cdb_tag = 6'd9;
        rd_tag = {6'd9, 6'd0};
        tick();
        cdb_valid = 1'b0;
        tick();
        idle();
        tick();

        // Allocate every preg back-to-back, then flush with a CDB
        for (int t = 0; t < 64; t++) begin
            alloc_valid = 1'b1; alloc_tag = 6'(t);
            tick();
        end
        idle();
        tick();
        chk("busy64 full", {57'b0, busy64}, 
`ifdef PREG_ZERO_EN
            64'd63);
`else
            64'd64);
`endif
        flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 6'd3;
        tick();
        idle();
        tick();

        // Out-of-range tag on the 48-entry table: single-cycle error, no change
        alloc_valid = 1'b1; alloc_tag = 6'd50; rd_tag = {6'd50, 6'd50};
        tick();
        idle();
        tick();
        tick();

        // Tag 0 behaviour (hardwired ready only with PREG_ZERO_EN)
        alloc_valid = 1'b1; alloc_tag = 6'd0; rd_tag = {6'd0, 6'd0};
        tick();
        idle();
        tick();

        // Mid-operation reset
        alloc_valid = 1'b1; alloc_tag = 6'd17;
        tick();
        idle();
        reset = 1'b1;
        tick();
        idle();
        tick();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            reset       = ($urandom_range(0, 99) == 0);
            flush       = ($urandom_range(0, 49) == 0);
            alloc_valid = $urandom_range(0, 1) == 1;
            alloc_tag   = 6'($urandom_range(0, 63));
            cdb_valid   = $urandom_range(0, 1) == 1;
            cdb_tag     = ($urandom_range(0, 3) == 0) ? alloc_tag : 6'($urandom_range(0, 63));
            rd_tag      = {6'($urandom_range(0, 63)), ($urandom_range(0, 1) == 1) ? cdb_tag : 6'($urandom_range(0, 63))};
            tick();
        end
        idle();
        tick();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
`default_nettype wire
